rf_write_arbiter: RTL
=====================

# rf_write_arbiter

Shares the single write port of the 32×32 register file between several writeback requesters (ALU result, memory load, link/jump writeback). Each requester presents a valid/ready write request. One request per cycle is granted and registered onto the register file's `RegWriteSig`/`writeReg`/`writeData` inputs. The block also keeps a 32-entry pending-write scoreboard that the decode stage uses to stall on registers with outstanding writes.

## Interface
- `NREQ`, default 2: number of write requesters (2..4).
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register index width.
- `clk` in 1: rising-edge clock (single clock domain).
- `rst_n` in 1: reset; asynchronous, active-low.
- `req_valid` in NREQ: per-requester write request.
- `req_ready` out NREQ: per-requester grant; a transfer occurs when `req_valid[i] & req_ready[i]` at a rising edge.
- `req_addr` in NREQ*ADDR_W: packed destination indices; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_data` in NREQ*DATA_W: packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- `issue_valid` in 1: decode has issued an instruction that will write `issue_reg`.
- `issue_reg` in ADDR_W: destination of the issued instruction.
- `RegWriteSig` out 1: write enable to the register file.
- `writeReg` out ADDR_W: write index to the register file.
- `writeData` out DATA_W: write data to the register file.
- `busy` out 32: scoreboard; bit r=1 means a write to register r is outstanding.

## Operation
- Arbitration:
  - `req_ready` is combinational from `req_valid` and the priority state.
  - At most one bit of `req_ready` is set, and only for a requester whose `req_valid` is set.
  - A requester with `req_valid` low never receives `req_ready`.
- Output register:
  - On an accepted request, the next edge loads `writeReg` and `writeData` with the granted requester's fields.
  - The same edge sets `RegWriteSig`=1, except when the granted address is 0, in which case `RegWriteSig`=0.
  - With no accepted request, `RegWriteSig`=0 and `writeReg`/`writeData` hold their previous values.
- Scoreboard:
  - `issue_valid` with `issue_reg`≠0 sets `busy[issue_reg]` at the edge.
  - An accepted request clears `busy[addr]` at the edge.
  - If the same register is set and cleared at the same edge, set wins, because a newer producer is in flight.
  - `busy[0]` is constant 0. `issue_reg`=0 is ignored.
- Requesters must hold `req_valid`, `req_addr` and `req_data` stable until accepted. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous release), all outputs: `RegWriteSig`=0, `writeReg`=0, `writeData`=0, `busy`=0, round-robin pointer=0.
- Reset asserted between acceptance and the register file write drops that write. The requester sees its transfer as completed.
- Latency: request accepted at edge N → `RegWriteSig` high during cycle N..N+1 → register file writes at edge N+1.
- Throughput: one write per cycle sustained; back-to-back grants to the same requester are allowed.
- Data written at edge N+1 reads from the register file after edge N+1. The arbiter provides no bypass.
- `busy[r]` falls at the acceptance edge N, one cycle before the register file write. The decode stage needs a forwarding path or must re-check `busy` one cycle later.

## Configuration
- `RF_ARB_RR_EN` defined:
  - Round-robin. A pointer holds the index after the last granted requester, and search starts there, wrapping at NREQ.
  - The pointer updates only on an accepted request.
- `RF_ARB_RR_EN` undefined:
  - Fixed priority, requester 0 highest.
  - No pointer register; it is not instantiated.

## Structure
- Package `rf_pkg`: `ADDR_W`=5, `DATA_W`=32, `NUM_REGS`=32, and a `rf_wr_req_t` struct {addr, data}.
- One sub-module, `rf_rr_arbiter`: `NREQ`-wide valid-in/grant-out with an internal pointer. It collapses to fixed priority without `RF_ARB_RR_EN`.
- The scoreboard and output register stay in the top module.

## Test plan
- Reset release, no requests: `RegWriteSig`=0 and `busy`=0 for 10 cycles.
- Req0 only, addr 20, data 50: `req_ready[0]` high the same cycle; `RegWriteSig`=1, `writeReg`=20, `writeData`=50 the next cycle; register file reads 50 from reg 20 afterward.
- Req0 (addr 3, data 7) and req1 (addr 4, data 9) held 4 cycles:
  - With `RF_ARB_RR_EN`, grant order is 0,1,0,1.
  - Without it, grant order is 0,0,0,0 and req1 is starved.
- Issue reg 5, then write reg 5 two cycles later: `busy[5]` is 1 for two cycles and 0 after the acceptance edge. At the same edge, issue reg 5 plus write reg 5 leaves `busy[5]`=1.
- Write addr 0, data 0xFFFF_FFFF: `req_ready` granted, `RegWriteSig` stays 0, reg 0 still reads 0. `issue_reg`=0 leaves `busy`=0.
- Assert `rst_n` low mid-stream, one cycle after acceptance: `RegWriteSig` goes 0 immediately, `busy` clears, and the dropped write is absent from the register file.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // One writeback request as seen by the register file write port.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_req_t;

  // Requester index following idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// One-hot grant among NREQ valid inputs.
// RF_ARB_RR_EN selects round-robin with a pointer register; otherwise
// fixed priority (requester 0 highest) with no state at all.
module rf_rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant
);

`ifdef RF_ARB_RR_EN
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  // Search from the pointer, wrapping; a grant moves the pointer past the winner.
  always_comb begin
    logic        found;
    int          idx;
    logic [PW-1:0] idx_n;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_n = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(ptr_q) + k) % NREQ;
      idx_n = PW'(idx);
      if (!found && valid[idx_n]) begin
        grant[idx_n] = 1'b1;
        found        = 1'b1;
        ptr_d        = PW'(wrap_inc(int unsigned'(idx), NREQ));
      end
    end
  end

  // Pointer register; only a grant (which is always an accepted transfer) moves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  // Isolate the lowest set valid bit.
  always_comb begin
    grant = valid & (~valid + NREQ'(1));
  end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter with pending-write scoreboard.
// Optional round-robin arbitration: define RF_ARB_RR_EN.
module rf_write_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*ADDR_W-1:0]       req_addr,
  input  logic [NREQ*DATA_W-1:0]       req_data,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_reg,
  output logic                         RegWriteSig,
  output logic [ADDR_W-1:0]            writeReg,
  output logic [DATA_W-1:0]            writeData,
  output logic [rf_pkg::NUM_REGS-1:0]  busy
);
  import rf_pkg::*;

  rf_wr_req_t [NREQ-1:0] req;
  rf_wr_req_t [NREQ-1:0] masked;
  rf_wr_req_t [NREQ:0]   or_chain;
  rf_wr_req_t            sel;
  logic [NREQ-1:0]       grant;
  logic                  acc;

  logic                  reg_write_sig_q, reg_write_sig_d;
  logic [ADDR_W-1:0]     write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;

  rf_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .grant (grant)
  );

  // Unpack requesters and AND-OR select the granted one (grant is one-hot).
  assign or_chain[0] = '0;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req[i].addr    = req_addr[i*ADDR_W +: ADDR_W];
    assign req[i].data    = req_data[i*DATA_W +: DATA_W];
    assign masked[i]      = grant[i] ? req[i] : '0;
    assign or_chain[i+1]  = or_chain[i] | masked[i];
  end
  assign sel       = or_chain[NREQ];
  assign acc       = |grant;
  assign req_ready = grant;

  // Next write-port state: load on accept, suppress enable for r0, hold otherwise.
  always_comb begin
    reg_write_sig_d = 1'b0;
    write_reg_d     = write_reg_q;
    write_data_d    = write_data_q;
    if (acc) begin
      reg_write_sig_d = (sel.addr != '0);
      write_reg_d     = sel.addr;
      write_data_d    = sel.data;
    end
  end

  // Scoreboard: clear on accept, then set on issue so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (acc) busy_d[sel.addr] = 1'b0;
    if (issue_valid && issue_reg != '0) busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Output and scoreboard registers; reset drops any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_sig_q <= 1'b0;
      write_reg_q     <= '0;
      write_data_q    <= '0;
      busy_q          <= '0;
    end else begin
      reg_write_sig_q <= reg_write_sig_d;
      write_reg_q     <= write_reg_d;
      write_data_q    <= write_data_d;
      busy_q          <= busy_d;
    end
  end

  assign RegWriteSig = reg_write_sig_q;
  assign writeReg    = write_reg_q;
  assign writeData   = write_data_q;
  assign busy        = busy_q;

endmodule
